// File: rtl/diram_phy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : diram_phy_responder
//  Purpose  : DRAM-side responder for a manager's DFI command/data interface.
//             Decodes ACT/RD/WR/PRE, tracks per-bank open state and row,
//             stores write bursts in a small backing array, and returns
//             read bursts after a fixed latency. Protocol violations drop
//             the offending command and raise a one-cycle error pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   1        only clock
//    reset_poweron    in   1        asynchronous, active-low reset
//    dfi__phy__cs     in   1        command valid
//    dfi__phy__cmd1   in   1        command code, upper bit
//    dfi__phy__cmd0   in   1        command code, lower bit
//    dfi__phy__bank   in   BANK_W   target bank
//    dfi__phy__addr   in   ADDR_W   row (ACT) or column (RD/WR)
//    dfi__phy__data   in   DATA_W   write beats
//    phy__dfi__valid  out  1        read beat valid
//    phy__dfi__data   out  DATA_W   read beat (holds last beat when idle)
//    phy__err         out  1        one-cycle protocol-violation pulse
//    phy__err_code    out  2        cause of the last violation
// ============================================================================
module diram_phy_responder #(
  parameter int DATA_W    = 32,
  parameter int BANK_W    = 3,
  parameter int ADDR_W    = 12,
  parameter int COL_W     = 4,
  parameter int RD_LAT    = 4,
  parameter int BURST_LEN = 2
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              dfi__phy__cs,
  input  logic              dfi__phy__cmd1,
  input  logic              dfi__phy__cmd0,
  input  logic [BANK_W-1:0] dfi__phy__bank,
  input  logic [ADDR_W-1:0] dfi__phy__addr,
  input  logic [DATA_W-1:0] dfi__phy__data,
  output logic              phy__dfi__valid,
  output logic [DATA_W-1:0] phy__dfi__data,
  output logic              phy__err,
  output logic [1:0]        phy__err_code
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_nbanks  = 2 ** BANK_W;
  localparam int c_idx_w   = BANK_W + COL_W;
  localparam int c_depth   = 2 ** c_idx_w;
  localparam int c_sched_w = RD_LAT + BURST_LEN;
  localparam int c_cnt_w   = 4;

  localparam logic [1:0] c_cmd_act = 2'b00;
  localparam logic [1:0] c_cmd_rd  = 2'b01;
  localparam logic [1:0] c_cmd_wr  = 2'b10;
  localparam logic [1:0] c_cmd_pre = 2'b11;

  localparam logic [1:0] c_err_act_open   = 2'd1;
  localparam logic [1:0] c_err_bank_shut  = 2'd2;
  localparam logic [1:0] c_err_collision  = 2'd3;

  localparam logic [c_cnt_w-1:0]   c_last_beat = c_cnt_w'(BURST_LEN - 1);
  localparam logic [c_sched_w-1:0] c_beat_mask = c_sched_w'((2 ** BURST_LEN) - 1);

  typedef enum logic [0:0] {
    WIDLE  = 1'b0,
    WBURST = 1'b1
  } wstate_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  r_mem [c_depth];

  logic [c_nbanks-1:0] r_bank_open;
  logic [ADDR_W-1:0]   r_bank_row [c_nbanks];

  wstate_t             r_wstate;
  wstate_t             w_wstate_nxt;
  logic [c_cnt_w-1:0]  r_wcnt;
  logic [c_cnt_w-1:0]  w_wcnt_nxt;
  logic [BANK_W-1:0]   r_wbank;
  logic [COL_W-1:0]    r_wcol;
  logic                w_mem_we;
  logic [c_idx_w-1:0]  w_mem_idx;

  // Bit k set: a read beat is registered onto the output at the k-th
  // upcoming clock edge (k = 0 is the next edge).
  logic [c_sched_w-1:0] r_sched;
  logic [c_sched_w-1:0] w_sched_nxt;

  logic                w_launch;
  logic [c_idx_w-1:0]  w_launch_idx;

  logic                r_seq_act;
  logic [BANK_W-1:0]   r_seq_bank;
  logic [COL_W-1:0]    r_seq_col;
  logic [c_cnt_w-1:0]  r_seq_cnt;

  logic                r_pre_vld;
  logic [DATA_W-1:0]   r_pre_data;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;

  logic                r_err;
  logic [1:0]          r_err_code;

  logic [1:0]          w_cmd;
  logic [COL_W-1:0]    w_col;
  logic [c_idx_w-1:0]  w_cmd_idx;
  logic                w_bank_is_open;
  logic                w_wr_clash;
  logic                w_rd_clash;
  logic                w_viol;
  logic [1:0]          w_viol_code;
  logic                w_act_ok;
  logic                w_pre_ok;
  logic                w_rd_ok;
  logic                w_wr_ok;
  logic                w_unused_row;

  // --------------------------------------------------------------------------
  // Command decode and protocol checking
  // --------------------------------------------------------------------------
  assign w_cmd          = {dfi__phy__cmd1, dfi__phy__cmd0};
  assign w_col          = dfi__phy__addr[COL_W-1:0];
  assign w_cmd_idx      = {dfi__phy__bank, w_col};
  assign w_bank_is_open = r_bank_open[dfi__phy__bank];

  // A WR now occupies the next BURST_LEN edges; a RD now lands its beats
  // RD_LAT..RD_LAT+BURST_LEN-1 edges out. Either clashes with any beat
  // already scheduled in its window.
  assign w_wr_clash = |r_sched[BURST_LEN-1:0];
  assign w_rd_clash = |r_sched[c_sched_w-1:RD_LAT];

  always_comb begin
    w_viol      = 1'b0;
    w_viol_code = 2'd0;
    w_act_ok    = 1'b0;
    w_pre_ok    = 1'b0;
    w_rd_ok     = 1'b0;
    w_wr_ok     = 1'b0;
    if (dfi__phy__cs) begin
      if (r_wstate == WBURST) begin
        w_viol      = 1'b1;
        w_viol_code = c_err_collision;
      end else begin
        case (w_cmd)
          c_cmd_act: begin
            if (w_bank_is_open) begin
              w_viol      = 1'b1;
              w_viol_code = c_err_act_open;
            end else begin
              w_act_ok = 1'b1;
            end
          end
          c_cmd_rd: begin
            if (!w_bank_is_open) begin
              w_viol      = 1'b1;
              w_viol_code = c_err_bank_shut;
            end else if (w_rd_clash) begin
              w_viol      = 1'b1;
              w_viol_code = c_err_collision;
            end else begin
              w_rd_ok = 1'b1;
            end
          end
          c_cmd_wr: begin
            if (!w_bank_is_open) begin
              w_viol      = 1'b1;
              w_viol_code = c_err_bank_shut;
            end else if (w_wr_clash) begin
              w_viol      = 1'b1;
              w_viol_code = c_err_collision;
            end else begin
              w_wr_ok = 1'b1;
            end
          end
          default: begin
            // PRE is always legal; on a closed bank it changes nothing.
            w_pre_ok = 1'b1;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-bank state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_bank_open <= '0;
      for (int b = 0; b < c_nbanks; b++) begin
        r_bank_row[b] <= '0;
      end
    end else if (w_act_ok) begin
      r_bank_open[dfi__phy__bank] <= 1'b1;
      r_bank_row[dfi__phy__bank]  <= dfi__phy__addr;
    end else if (w_pre_ok) begin
      r_bank_open[dfi__phy__bank] <= 1'b0;
    end
  end

  // The row is kept for protocol visibility only; storage aliases rows.
  always_comb begin
    w_unused_row = 1'b0;
    for (int b = 0; b < c_nbanks; b++) begin
      w_unused_row = w_unused_row ^ (^r_bank_row[b]);
    end
  end

  // --------------------------------------------------------------------------
  // Error reporting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_err <= w_viol;
      if (w_viol) begin
        r_err_code <= w_viol_code;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_wstate <= WIDLE;
      r_wcnt   <= '0;
      r_wbank  <= '0;
      r_wcol   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wcnt   <= w_wcnt_nxt;
      if (w_wr_ok) begin
        r_wbank <= dfi__phy__bank;
        r_wcol  <= w_col;
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcnt_nxt   = r_wcnt;
    w_mem_we     = 1'b0;
    w_mem_idx    = w_cmd_idx;
    case (r_wstate)
      WIDLE: begin
        if (w_wr_ok) begin
          w_mem_we = 1'b1;
          if (BURST_LEN > 1) begin
            w_wstate_nxt = WBURST;
            w_wcnt_nxt   = c_cnt_w'(1);
          end
        end
      end
      WBURST: begin
        // Beats wrap within the bank's column space.
        w_mem_we  = 1'b1;
        w_mem_idx = {r_wbank, r_wcol + COL_W'(r_wcnt)};
        if (r_wcnt == c_last_beat) begin
          w_wstate_nxt = WIDLE;
          w_wcnt_nxt   = '0;
        end else begin
          w_wcnt_nxt = r_wcnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_wstate_nxt = WIDLE;
        w_wcnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read schedule map (used for collision checks)
  // --------------------------------------------------------------------------
  assign w_sched_nxt = {1'b0, r_sched[c_sched_w-1:1]}
                     | (w_rd_ok ? (c_beat_mask << (RD_LAT - 1)) : '0);

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_sched <= '0;
    end else begin
      r_sched <= w_sched_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read launch delay. The beat sequencer must be loaded RD_LAT-2 edges
  // after the RD edge: one edge for the storage read and one for the output
  // register follow it.
  // --------------------------------------------------------------------------
  if (RD_LAT > 2) begin : g_rd_delay
    localparam int c_dly = RD_LAT - 2;
    logic [c_dly-1:0]   r_dly_vld;
    logic [c_idx_w-1:0] r_dly_idx [c_dly];

    always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
        r_dly_vld <= '0;
        for (int k = 0; k < c_dly; k++) begin
          r_dly_idx[k] <= '0;
        end
      end else begin
        r_dly_vld[0] <= w_rd_ok;
        r_dly_idx[0] <= w_cmd_idx;
        for (int k = 1; k < c_dly; k++) begin
          r_dly_vld[k] <= r_dly_vld[k-1];
          r_dly_idx[k] <= r_dly_idx[k-1];
        end
      end
    end

    assign w_launch     = r_dly_vld[c_dly-1];
    assign w_launch_idx = r_dly_idx[c_dly-1];
  end else begin : g_rd_nodelay
    assign w_launch     = w_rd_ok;
    assign w_launch_idx = w_cmd_idx;
  end

  // --------------------------------------------------------------------------
  // Beat sequencer: walks BURST_LEN columns, one per cycle. Read spacing
  // rules guarantee a new launch never lands before the current burst's
  // last beat has been issued, so a launch may simply take priority.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_seq_act  <= 1'b0;
      r_seq_bank <= '0;
      r_seq_col  <= '0;
      r_seq_cnt  <= '0;
    end else if (w_launch) begin
      r_seq_act  <= 1'b1;
      r_seq_bank <= w_launch_idx[c_idx_w-1:COL_W];
      r_seq_col  <= w_launch_idx[COL_W-1:0];
      r_seq_cnt  <= '0;
    end else if (r_seq_act) begin
      if (r_seq_cnt == c_last_beat) begin
        r_seq_act <= 1'b0;
      end else begin
        r_seq_cnt <= r_seq_cnt + c_cnt_w'(1);
        r_seq_col <= r_seq_col + COL_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Backing storage (not reset). The synchronous read samples the array
  // before this edge's write lands, giving read-before-write on a shared
  // index.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= dfi__phy__data;
    end
    if (r_seq_act) begin
      r_pre_data <= r_mem[{r_seq_bank, r_seq_col}];
    end
  end

  // --------------------------------------------------------------------------
  // Read output stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_pre_vld  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_pre_vld  <= r_seq_act;
      r_rd_valid <= r_pre_vld;
      if (r_pre_vld) begin
        r_rd_data <= r_pre_data;
      end
    end
  end

  assign phy__dfi__valid = r_rd_valid;
  assign phy__dfi__data  = r_rd_data;
  assign phy__err        = r_err;
  assign phy__err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_diram_phy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_diram_phy_responder
//  Purpose  : Directed self-checking bench for diram_phy_responder with the
//             default parameters (RD_LAT=4, BURST_LEN=2, COL_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_diram_phy_responder;

  localparam logic [1:0] ACT = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] PRE = 2'b11;

  logic        clk;
  logic        reset_poweron;
  logic        cs;
  logic        cmd1;
  logic        cmd0;
  logic [2:0]  bank;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        valid;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;

  int total;
  int bad;
  int nvalid;

  diram_phy_responder dut (
    .clk             (clk),
    .reset_poweron   (reset_poweron),
    .dfi__phy__cs    (cs),
    .dfi__phy__cmd1  (cmd1),
    .dfi__phy__cmd0  (cmd0),
    .dfi__phy__bank  (bank),
    .dfi__phy__addr  (addr),
    .dfi__phy__data  (wdata),
    .phy__dfi__valid (valid),
    .phy__dfi__data  (rdata),
    .phy__err        (err),
    .phy__err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [2:0] b,
                        input logic [11:0] a, input logic [31:0] d);
    cs = 1'b1;
    {cmd1, cmd0} = c;
    bank = b;
    addr = a;
    wdata = d;
    step();
    cs = 1'b0;
    {cmd1, cmd0} = 2'b00;
    wdata = '0;
  endtask

  task automatic nop(input logic [31:0] d);
    cs = 1'b0;
    wdata = d;
    step();
    wdata = '0;
  endtask

  // RD then watch six edges: beats expected at RD+4 and RD+5.
  task automatic rd_burst(input string tag, input logic [2:0] b, input logic [11:0] c,
                          input logic [31:0] e0, input logic [31:0] e1, input bit chk1);
    do_cmd(RD, b, c, 32'h0);
    chk({tag, "_rd_err"}, {31'b0, err}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      nop(32'h0);
      chk($sformatf("%s_valid_%0d", tag, k), {31'b0, valid}, {31'b0, (k == 4 || k == 5)});
      if (k == 4) chk({tag, "_beat0"}, rdata, e0);
      if (k == 5 && chk1) chk({tag, "_beat1"}, rdata, e1);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_poweron = 1'b0;
    cs = 1'b0;
    cmd1 = 1'b0;
    cmd0 = 1'b0;
    bank = '0;
    addr = '0;
    wdata = '0;

    // Reset state
    step();
    step();
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_code", {30'b0, err_code}, 32'd0);
    reset_poweron = 1'b1;
    step();

    // Basic write/read
    do_cmd(ACT, 3'd2, 12'd5, 32'h0);
    chk("basic_act_err", {31'b0, err}, 32'd0);
    do_cmd(WR, 3'd2, 12'd3, 32'hA0);
    chk("basic_wr_err", {31'b0, err}, 32'd0);
    nop(32'hA1);
    rd_burst("basic", 3'd2, 12'd3, 32'hA0, 32'hA1, 1'b1);

    // Column wrap
    do_cmd(ACT, 3'd1, 12'd7, 32'h0);
    do_cmd(WR, 3'd1, 12'd15, 32'h11);
    nop(32'h22);
    rd_burst("wrap15", 3'd1, 12'd15, 32'h11, 32'h22, 1'b1);
    rd_burst("wrap0", 3'd1, 12'd0, 32'h22, 32'h0, 1'b0);

    // RD to closed bank
    do_cmd(RD, 3'd4, 12'd0, 32'h0);
    chk("closed_err", {31'b0, err}, 32'd1);
    chk("closed_code", {30'b0, err_code}, 32'd2);
    nvalid = 0;
    for (int k = 1; k <= 6; k++) begin
      nop(32'h0);
      if (k == 1) begin
        chk("closed_err_pulse", {31'b0, err}, 32'd0);
        chk("closed_code_hold", {30'b0, err_code}, 32'd2);
      end
      nvalid += int'(valid);
    end
    chk("closed_no_valid", nvalid, 32'd0);

    // Double ACT
    do_cmd(ACT, 3'd0, 12'h123, 32'h0);
    chk("act1_err", {31'b0, err}, 32'd0);
    do_cmd(ACT, 3'd0, 12'h456, 32'h0);
    chk("act2_err", {31'b0, err}, 32'd1);
    chk("act2_code", {30'b0, err_code}, 32'd1);
    nop(32'h0);
    chk("act2_row_kept", {20'b0, dut.r_bank_row[0]}, 32'h123);

    // Command during WBURST: PRE is dropped, burst completes with its beat
    do_cmd(ACT, 3'd3, 12'd1, 32'h0);
    do_cmd(WR, 3'd3, 12'd5, 32'hB0);
    do_cmd(PRE, 3'd3, 12'd0, 32'hB1);
    chk("wburst_err", {31'b0, err}, 32'd1);
    chk("wburst_code", {30'b0, err_code}, 32'd3);
    rd_burst("wburst", 3'd3, 12'd5, 32'hB0, 32'hB1, 1'b1);

    // Read pacing: RDs two cycles apart give four continuous beats
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    nop(32'h0);
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    chk("pace2_err", {31'b0, err}, 32'd0);
    for (int k = 3; k <= 8; k++) begin
      nop(32'h0);
      chk($sformatf("pace2_valid_%0d", k), {31'b0, valid}, {31'b0, (k >= 4 && k <= 7)});
      if (k == 4 || k == 6) chk($sformatf("pace2_data_%0d", k), rdata, 32'hA0);
      if (k == 5 || k == 7) chk($sformatf("pace2_data_%0d", k), rdata, 32'hA1);
    end

    // Read pacing: RDs one cycle apart, second rejected
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    chk("pace1_err", {31'b0, err}, 32'd1);
    chk("pace1_code", {30'b0, err_code}, 32'd3);
    nvalid = 0;
    for (int k = 2; k <= 8; k++) begin
      nop(32'h0);
      nvalid += int'(valid);
    end
    chk("pace1_beats", nvalid, 32'd2);

    // Reset in the middle of a read
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    nop(32'h0);
    nop(32'h0);
    reset_poweron = 1'b0;
    nvalid = 0;
    nop(32'h0);
    nvalid += int'(valid);
    nop(32'h0);
    nvalid += int'(valid);
    reset_poweron = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      nop(32'h0);
      nvalid += int'(valid);
    end
    chk("rstmid_no_valid", nvalid, 32'd0);
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    chk("rstmid_closed_err", {31'b0, err}, 32'd1);
    chk("rstmid_closed_code", {30'b0, err_code}, 32'd2);
    do_cmd(RD, 3'd1, 12'd15, 32'h0);
    chk("rstmid_bank1_code", {30'b0, err_code}, 32'd2);
    do_cmd(ACT, 3'd2, 12'd9, 32'h0);
    chk("rstmid_act_err", {31'b0, err}, 32'd0);
    rd_burst("rstmid_kept", 3'd2, 12'd3, 32'hA0, 32'hA1, 1'b1);

    // Same-cycle hazard: beat 1 of the WR lands on col 4 while col 4 is read
    do_cmd(RD, 3'd2, 12'd4, 32'h0);
    nop(32'h0);
    do_cmd(WR, 3'd2, 12'd3, 32'hC0);
    chk("hazard_wr_err", {31'b0, err}, 32'd0);
    nop(32'hC1);
    nop(32'h0);
    chk("hazard_valid", {31'b0, valid}, 32'd1);
    chk("hazard_old_data", rdata, 32'hA1);
    nop(32'h0);
    nop(32'h0);
    rd_burst("hazard_new", 3'd2, 12'd3, 32'hC0, 32'hC1, 1'b1);

    // PRE one cycle after RD: beats still delivered
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    do_cmd(PRE, 3'd2, 12'd0, 32'h0);
    chk("pre_err", {31'b0, err}, 32'd0);
    for (int k = 2; k <= 6; k++) begin
      nop(32'h0);
      chk($sformatf("pre_valid_%0d", k), {31'b0, valid}, {31'b0, (k == 4 || k == 5)});
      if (k == 4) chk("pre_beat0", rdata, 32'hC0);
      if (k == 5) chk("pre_beat1", rdata, 32'hC1);
    end
    nop(32'h0);
    chk("pre_hold_data", rdata, 32'hC1);
    do_cmd(RD, 3'd2, 12'd3, 32'h0);
    chk("pre_closed_code", {30'b0, err_code}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/diram_phy_responder.md
# diram_phy_responder

- DRAM-side responder for the manager's DFI command/data interface.
- Decodes chip-select and command strobes, tracks per-bank open rows, and stores write bursts in a small backing array.
- Returns read bursts after a fixed latency on `phy__dfi__valid`/`phy__dfi__data`.
- Used in system simulation in place of the physical DiRAM stack, one instance per manager port.

## Interface
- `DATA_W`, default 32: width of the data bus in both directions.
- `BANK_W`, default 3: bank select width.
- `ADDR_W`, default 12: address width. Carries the row on ACT and the column on RD/WR.
- `COL_W`, default 4: column bits used to index storage. Storage depth is 2^(BANK_W+COL_W).
- `RD_LAT`, default 4: cycles from RD command to first read beat. Legal range is 2 or more.
- `BURST_LEN`, default 2: beats per RD/WR burst. Legal range is 1 to 8.

Ports:
- `clk`  in  1: the only clock.
- `reset_poweron`  in  1: asynchronous, active-low reset.
- `dfi__phy__cs`  in  1: command valid.
- `dfi__phy__cmd1`, `dfi__phy__cmd0`  in  1 each: command code.
- `dfi__phy__bank`  in  BANK_W: target bank.
- `dfi__phy__addr`  in  ADDR_W: row or column.
- `dfi__phy__data`  in  DATA_W: write beats.
- `phy__dfi__valid`  out  1: read beat valid.
- `phy__dfi__data`  out  DATA_W: read beat.
- `phy__err`  out  1: one-cycle protocol-violation pulse.
- `phy__err_code`  out  2: cause of the last violation, held until the next one.

## Operation
- Commands are decoded when `cs`=1, using {cmd1,cmd0}:
  - 00 ACT: open the row for the bank.
  - 01 RD: read burst from the column.
  - 10 WR: write burst to the column. Beat 0 is on `dfi__phy__data` in the command cycle.
  - 11 PRE: close the bank.
- `cs`=0 is a NOP, except that it carries write data beats during a write burst.
- Per-bank state is an open bit plus the row register. The row is checked for protocol only. Rows alias in storage, and the storage index is {bank, col}.
- Beat b of a burst addresses column (col+b) mod 2^COL_W, so bursts wrap within the bank.
- Write FSM:
  - IDLE: a legal WR writes beat 0 and goes to WBURST with beat count 1. With BURST_LEN=1 it stays in IDLE.
  - WBURST: each cycle writes the `dfi__phy__data` beat and increments the count. After the beat with count = BURST_LEN-1 it returns to IDLE.
- Read pipeline:
  - A legal RD at cycle T schedules beats at T+RD_LAT+b, for b = 0 to BURST_LEN-1.
  - Storage is read in the cycle before each beat and the output is registered.
- Violations: the offending command is dropped, with no state change and no storage access. `phy__err` pulses and the code is recorded.
  - Code 1: ACT to a bank that is already open.
  - Code 2: RD or WR to a closed bank.
  - Code 3 for any of the following:
    - any command (`cs`=1) while the write FSM is in WBURST; the burst continues;
    - a RD whose beats would overlap a pending read's beats, i.e. a RD within BURST_LEN-1 cycles of the previous accepted RD;
    - a WR whose burst would overlap scheduled read beats.
- PRE to a closed bank is a legal no-op.
- PRE to a bank with scheduled read beats is legal. Those beats are still delivered.
- A write and a scheduled storage read to the same index in the same cycle: the read returns the old data (read-before-write).
- Reset behaviour:
  - Asynchronous assertion closes all banks, returns the write FSM to IDLE, and discards all scheduled reads.
  - Storage contents are not reset.
  - A burst in progress at reset is abandoned: there is no partial completion and no error.

## Timing
- Reset values: `phy__dfi__valid`=0, `phy__dfi__data`=0, `phy__err`=0, `phy__err_code`=0.
- All inputs are sampled on the rising edge of `clk`.
- ACT, PRE and the bank state update take effect in the cycle after the command. ACT then RD in consecutive cycles is legal.
- Read latency is exactly RD_LAT cycles from the RD command edge to the first edge with `valid`=1.
- `valid` is high for exactly BURST_LEN consecutive cycles per RD. Back-to-back RDs every BURST_LEN cycles give continuous `valid`.
- `phy__dfi__data` holds its last beat while `valid`=0.
- Write beat b is sampled at command edge +b. It is visible to a RD issued at command edge +b+1 or later.
- `phy__err` is asserted the cycle after the offending command. `phy__err_code` updates in the same cycle.

## Test plan
- **Basic write/read:** ACT bank 2 row 5; WR bank 2 col 3 with beats 0xA0, 0xA1; RD bank 2 col 3 -> `valid` at RD+4 and RD+5 with data 0xA0, 0xA1; no error.
- **Column wrap:** WR bank 1 col 15 with beats 0x11, 0x22; RD col 15 -> 0x11, 0x22; RD col 0 -> 0x22 first.
- **Protocol errors:**
  - RD to closed bank 4 -> `err` pulse, code 2, no `valid`.
  - ACT twice to bank 0 -> code 1, and the row stays at the first value.
  - Command during WBURST -> code 3, and the write completes intact.
- **Read pacing:** RDs at T and T+2 -> 4 consecutive `valid` cycles. RDs at T and T+1 -> second RD gets code 3, and only 2 beats are returned.
- **Reset mid-operation:** deassert `reset_poweron` at RD+2 -> `valid` stays 0, all banks are closed (RD afterwards gives code 2), and data written earlier is still readable after a new ACT.
- **Same-cycle hazard and PRE:**
  - WR to the index being read in the same cycle -> old data returned.
  - PRE at RD+1 -> both beats are still delivered.
